// File: rtl/cmd_frame_pkg.sv
// ---------------------------------------------------------------------------
// cmd_frame_pkg
// Shared definitions for the command-frame controller:
//   - frame opcode bytes (AA/BB/CC/DD/EE/EF)
//   - controller state enum
//   - ERR_CODE values
//   - idle_decode(): maps a frame's first byte to the state it starts in
// ---------------------------------------------------------------------------
package cmd_frame_pkg;

  localparam logic [7:0] OPC_AA = 8'hAA;  // single write : addr, data
  localparam logic [7:0] OPC_BB = 8'hBB;  // single read  : addr
  localparam logic [7:0] OPC_CC = 8'hCC;  // ALU, operands in frame : opA, opB, fun
  localparam logic [7:0] OPC_DD = 8'hDD;  // ALU, stored operands   : fun
  localparam logic [7:0] OPC_EE = 8'hEE;  // burst write : addr, len, len+1 data
  localparam logic [7:0] OPC_EF = 8'hEF;  // burst read  : addr, len

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_LEN,
    ST_GET_DATA,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_PUSH,
    ST_GET_OPA,
    ST_GET_OPB,
    ST_GET_FUN,
    ST_ALU_WAIT,
    ST_ALU_PUSH
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_OP  = 2'b10;
  localparam logic [1:0] ERR_DROP    = 2'b11;

  // First byte of a frame -> state it leads to. ST_IDLE means "not an opcode".
  function automatic state_e idle_decode(input logic [7:0] op);
    case (op)
      OPC_AA, OPC_BB, OPC_EE, OPC_EF: return ST_GET_ADDR;
      OPC_CC:                         return ST_GET_OPA;
      OPC_DD:                         return ST_GET_FUN;
      default:                        return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmd_frame_ctrl_if
// Bundles every bus the controller talks to:
//   RX      : RX_P_DATA, RX_D_VLD
//   regfile : WrEn, RdEn, Address, WrData, RdData, RdData_Valid
//   ALU     : ALU_EN, ALU_FUN, GATE_EN, ALU_OUT, OUT_VALID
//   TX FIFO : FIFO_WR_DATA, FIFO_W_INC, FIFO_FULL
//   status  : BUSY, FRAME_ERR, ERR_CODE
// master = the controller, slave = the surrounding system.
// ---------------------------------------------------------------------------
interface cmd_frame_ctrl_if #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int OUT_SIZE = 16,
  parameter int FUN_W    = 4
);
  logic [DSIZE-1:0]    RX_P_DATA;
  logic                RX_D_VLD;
  logic [DSIZE-1:0]    RdData;
  logic                RdData_Valid;
  logic [OUT_SIZE-1:0] ALU_OUT;
  logic                OUT_VALID;
  logic                FIFO_FULL;

  logic                WrEn;
  logic                RdEn;
  logic [ASIZE-1:0]    Address;
  logic [DSIZE-1:0]    WrData;
  logic                ALU_EN;
  logic [FUN_W-1:0]    ALU_FUN;
  logic                GATE_EN;
  logic [DSIZE-1:0]    FIFO_WR_DATA;
  logic                FIFO_W_INC;
  logic                BUSY;
  logic                FRAME_ERR;
  logic [1:0]          ERR_CODE;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, GATE_EN,
           FIFO_WR_DATA, FIFO_W_INC, BUSY, FRAME_ERR, ERR_CODE
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, GATE_EN,
           FIFO_WR_DATA, FIFO_W_INC, BUSY, FRAME_ERR, ERR_CODE
  );
endinterface

// File: rtl/frame_timeout_cnt.sv
// ---------------------------------------------------------------------------
// frame_timeout_cnt
// Inter-byte watchdog. Loads TIMEOUT on clr, counts down while en, and flags
// expire once TIMEOUT idle cycles have elapsed and a further idle cycle is
// seen. A clear in the same cycle suppresses expire, so an event arriving
// exactly at the limit still wins.
// Ports: CLK, RST (async, active-low), clr, en -> expire (combinational).
// ---------------------------------------------------------------------------
module frame_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= CW'(TIMEOUT);
    end else if (clr) begin
      cnt_reg <= CW'(TIMEOUT);
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expire = en && !clr && (cnt_reg == '0);

endmodule

// File: rtl/cmd_frame_ctrl.sv
// ---------------------------------------------------------------------------
// cmd_frame_ctrl
// Decodes command frames from the UART RX, drives register-file writes/reads
// (single and burst), starts ALU operations and returns results to the TX
// FIFO. Every output is registered; strobes show up the cycle after the byte
// or valid that caused them.
// Ports: CLK, RST (async, active-low), bus (cmd_frame_ctrl_if.master).
// ---------------------------------------------------------------------------
module cmd_frame_ctrl
  import cmd_frame_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int OUT_SIZE = 16,
  parameter int FUN_W    = 4,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TIMEOUT  = 1023
) (
  input logic              CLK,
  input logic              RST,
  cmd_frame_ctrl_if.master bus
);
  localparam int NB    = OUT_SIZE / DSIZE;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  state_e              state_reg, state_next;
  logic [7:0]          opc_reg, opc_next;
  logic [ASIZE-1:0]    addr_reg, addr_next;       // next burst address
  logic [DSIZE-1:0]    cnt_reg, cnt_next;         // accesses left after the current one
  logic [DSIZE-1:0]    rd_data_reg, rd_data_next;
  logic [OUT_SIZE-1:0] alu_res_reg, alu_res_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [IDX_W-1:0]    last_idx_reg, last_idx_next;

  logic                wr_en_reg, wr_en_next;
  logic                rd_en_reg, rd_en_next;
  logic [ASIZE-1:0]    address_reg, address_next;
  logic [DSIZE-1:0]    wr_data_reg, wr_data_next;
  logic                alu_en_reg, alu_en_next;
  logic [FUN_W-1:0]    alu_fun_reg, alu_fun_next;
  logic                gate_en_reg, gate_en_next;
  logic [DSIZE-1:0]    fifo_data_reg, fifo_data_next;
  logic                fifo_inc_reg, fifo_inc_next;
  logic                busy_reg, busy_next;
  logic                frame_err_reg, frame_err_next;
  logic [1:0]          err_code_reg, err_code_next;

  logic [7:0]          rx_op;
  logic [ASIZE-1:0]    rx_addr;
  logic                accept, drop, push_last;
  logic                tmo_en, tmo_clr, tmo_expire;
  logic [DSIZE-1:0]    res_byte [NB];
  logic [NB-1:0]       out_nz;
  logic [IDX_W-1:0]    alu_last_idx;

  assign rx_op   = bus.RX_P_DATA[7:0];
  assign rx_addr = bus.RX_P_DATA[ASIZE-1:0];

  // Byte lanes of the latched result, and which lanes of the live ALU_OUT
  // are non-zero (used to trim leading zero bytes from the reply).
  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    assign res_byte[gi] = alu_res_reg[gi*DSIZE +: DSIZE];
    assign out_nz[gi]   = |bus.ALU_OUT[gi*DSIZE +: DSIZE];
  end

  always_comb begin
    alu_last_idx = '0;
    for (int i = 0; i < NB; i++) begin
      if (out_nz[i]) alu_last_idx = IDX_W'(i);
    end
  end

  // "Accepted" events restart the watchdog; dropped bytes do not.
  always_comb begin
    accept = 1'b0;
    case (state_reg)
      ST_GET_ADDR, ST_GET_LEN, ST_GET_DATA,
      ST_GET_OPA, ST_GET_OPB, ST_GET_FUN: accept = bus.RX_D_VLD;
      ST_RD_WAIT:                         accept = bus.RdData_Valid;
      ST_ALU_WAIT:                        accept = bus.OUT_VALID;
      default:                            accept = 1'b0;
    endcase
  end

  assign drop = bus.RX_D_VLD &&
                (state_reg inside {ST_RD_REQ, ST_RD_WAIT, ST_RD_PUSH, ST_ALU_WAIT, ST_ALU_PUSH});

  // Push states may stall on FIFO_FULL forever, so the watchdog sleeps there.
  assign tmo_en  = !(state_reg inside {ST_IDLE, ST_RD_PUSH, ST_ALU_PUSH});
  assign tmo_clr = !tmo_en || accept;

  assign push_last = (state_reg == ST_ALU_PUSH) && !bus.FIFO_FULL && (idx_reg == last_idx_reg);

  frame_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= ST_IDLE;
      opc_reg       <= '0;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      rd_data_reg   <= '0;
      alu_res_reg   <= '0;
      idx_reg       <= '0;
      last_idx_reg  <= '0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      address_reg   <= '0;
      wr_data_reg   <= '0;
      alu_en_reg    <= 1'b0;
      alu_fun_reg   <= '0;
      gate_en_reg   <= 1'b0;
      fifo_data_reg <= '0;
      fifo_inc_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      state_reg     <= state_next;
      opc_reg       <= opc_next;
      addr_reg      <= addr_next;
      cnt_reg       <= cnt_next;
      rd_data_reg   <= rd_data_next;
      alu_res_reg   <= alu_res_next;
      idx_reg       <= idx_next;
      last_idx_reg  <= last_idx_next;
      wr_en_reg     <= wr_en_next;
      rd_en_reg     <= rd_en_next;
      address_reg   <= address_next;
      wr_data_reg   <= wr_data_next;
      alu_en_reg    <= alu_en_next;
      alu_fun_reg   <= alu_fun_next;
      gate_en_reg   <= gate_en_next;
      fifo_data_reg <= fifo_data_next;
      fifo_inc_reg  <= fifo_inc_next;
      busy_reg      <= busy_next;
      frame_err_reg <= frame_err_next;
      err_code_reg  <= err_code_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (tmo_expire) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:     if (bus.RX_D_VLD) state_next = idle_decode(rx_op);
        ST_GET_ADDR: if (bus.RX_D_VLD) begin
                       if (opc_reg == OPC_AA)      state_next = ST_GET_DATA;
                       else if (opc_reg == OPC_BB) state_next = ST_RD_REQ;
                       else                        state_next = ST_GET_LEN;
                     end
        ST_GET_LEN:  if (bus.RX_D_VLD) state_next = (opc_reg == OPC_EE) ? ST_GET_DATA : ST_RD_REQ;
        ST_GET_DATA: if (bus.RX_D_VLD && (cnt_reg == '0)) state_next = ST_IDLE;
        ST_RD_REQ:   state_next = ST_RD_WAIT;
        ST_RD_WAIT:  if (bus.RdData_Valid) state_next = ST_RD_PUSH;
        ST_RD_PUSH:  if (!bus.FIFO_FULL) state_next = (cnt_reg == '0) ? ST_IDLE : ST_RD_REQ;
        ST_GET_OPA:  if (bus.RX_D_VLD) state_next = ST_GET_OPB;
        ST_GET_OPB:  if (bus.RX_D_VLD) state_next = ST_GET_FUN;
        ST_GET_FUN:  if (bus.RX_D_VLD) state_next = ST_ALU_WAIT;
        ST_ALU_WAIT: if (bus.OUT_VALID) state_next = ST_ALU_PUSH;
        ST_ALU_PUSH: if (push_last) state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values. Read strobes are issued on the transition
  // into RD_REQ so RdEn is high while the FSM sits in RD_REQ.
  always_comb begin
    opc_next       = opc_reg;
    addr_next      = addr_reg;
    cnt_next       = cnt_reg;
    rd_data_next   = rd_data_reg;
    alu_res_next   = alu_res_reg;
    idx_next       = idx_reg;
    last_idx_next  = last_idx_reg;
    wr_en_next     = 1'b0;
    rd_en_next     = 1'b0;
    address_next   = address_reg;
    wr_data_next   = wr_data_reg;
    alu_en_next    = 1'b0;
    alu_fun_next   = alu_fun_reg;
    fifo_data_next = fifo_data_reg;
    fifo_inc_next  = 1'b0;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;
    busy_next      = (state_next != ST_IDLE);
    gate_en_next   = (state_next == ST_ALU_WAIT) || (state_next == ST_ALU_PUSH) || push_last;

    if (tmo_expire) begin
      frame_err_next = 1'b1;
      err_code_next  = ERR_TIMEOUT;
    end else begin
      if (drop) begin
        frame_err_next = 1'b1;
        err_code_next  = ERR_DROP;
      end
      case (state_reg)
        ST_IDLE: if (bus.RX_D_VLD) begin
          opc_next = rx_op;
          if (idle_decode(rx_op) == ST_IDLE) begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_BAD_OP;
          end
        end
        ST_GET_ADDR: if (bus.RX_D_VLD) begin
          cnt_next  = '0;
          addr_next = rx_addr;
          if (opc_reg == OPC_BB) begin
            rd_en_next   = 1'b1;
            address_next = rx_addr;
            addr_next    = rx_addr + 1'b1;
          end
        end
        ST_GET_LEN: if (bus.RX_D_VLD) begin
          cnt_next = bus.RX_P_DATA;
          if (opc_reg == OPC_EF) begin
            rd_en_next   = 1'b1;
            address_next = addr_reg;
            addr_next    = addr_reg + 1'b1;
          end
        end
        ST_GET_DATA: if (bus.RX_D_VLD) begin
          wr_en_next   = 1'b1;
          address_next = addr_reg;
          wr_data_next = bus.RX_P_DATA;
          addr_next    = addr_reg + 1'b1;
          cnt_next     = cnt_reg - 1'b1;
        end
        ST_RD_WAIT: if (bus.RdData_Valid) rd_data_next = bus.RdData;
        ST_RD_PUSH: if (!bus.FIFO_FULL) begin
          fifo_inc_next  = 1'b1;
          fifo_data_next = rd_data_reg;
          if (cnt_reg != '0) begin
            cnt_next     = cnt_reg - 1'b1;
            rd_en_next   = 1'b1;
            address_next = addr_reg;
            addr_next    = addr_reg + 1'b1;
          end
        end
        ST_GET_OPA: if (bus.RX_D_VLD) begin
          wr_en_next   = 1'b1;
          address_next = ASIZE'(OPA_ADDR);
          wr_data_next = bus.RX_P_DATA;
        end
        ST_GET_OPB: if (bus.RX_D_VLD) begin
          wr_en_next   = 1'b1;
          address_next = ASIZE'(OPB_ADDR);
          wr_data_next = bus.RX_P_DATA;
        end
        ST_GET_FUN: if (bus.RX_D_VLD) begin
          alu_en_next  = 1'b1;
          alu_fun_next = bus.RX_P_DATA[FUN_W-1:0];
        end
        ST_ALU_WAIT: if (bus.OUT_VALID) begin
          alu_res_next  = bus.ALU_OUT;
          last_idx_next = alu_last_idx;
          idx_next      = '0;
        end
        ST_ALU_PUSH: if (!bus.FIFO_FULL) begin
          fifo_inc_next  = 1'b1;
          fifo_data_next = res_byte[idx_reg];
          idx_next       = idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.WrEn         = wr_en_reg;
  assign bus.RdEn         = rd_en_reg;
  assign bus.Address      = address_reg;
  assign bus.WrData       = wr_data_reg;
  assign bus.ALU_EN       = alu_en_reg;
  assign bus.ALU_FUN      = alu_fun_reg;
  assign bus.GATE_EN      = gate_en_reg;
  assign bus.FIFO_WR_DATA = fifo_data_reg;
  assign bus.FIFO_W_INC   = fifo_inc_reg;
  assign bus.BUSY         = busy_reg;
  assign bus.FRAME_ERR    = frame_err_reg;
  assign bus.ERR_CODE     = err_code_reg;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmd_frame_ctrl
// Directed bench for cmd_frame_ctrl: each task drives one frame scenario and
// compares against hand-computed values. A negedge monitor logs writes, reads,
// FIFO pushes and errors so the tasks can check whole transactions.
// ---------------------------------------------------------------------------
module tb_cmd_frame_ctrl;
  localparam int TIMEOUT = 1023;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  cmd_frame_ctrl_if #(.DSIZE(8), .ASIZE(4), .OUT_SIZE(16), .FUN_W(4)) bus ();

  cmd_frame_ctrl #(
    .DSIZE(8), .ASIZE(4), .OUT_SIZE(16), .FUN_W(4),
    .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  logic [32:0] outs;
  assign outs = {bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                 bus.GATE_EN, bus.FIFO_WR_DATA, bus.FIFO_W_INC, bus.BUSY,
                 bus.FRAME_ERR, bus.ERR_CODE};

  logic [11:0] wr_q[$];    // {Address, WrData}
  logic [8:0]  push_q[$];  // {GATE_EN, FIFO_WR_DATA}
  logic [1:0]  err_q[$];

  always @(negedge CLK) begin
    if (bus.WrEn)       wr_q.push_back({bus.Address, bus.WrData});
    if (bus.FIFO_W_INC) push_q.push_back({bus.GATE_EN, bus.FIFO_WR_DATA});
    if (bus.FRAME_ERR)  err_q.push_back(bus.ERR_CODE);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    tick();
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    push_q.delete();
    err_q.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    n_vec++; if (outs !== 33'h0) begin n_err++; $display("FAIL reset_outs: got %h expected 0", outs); end
    RST = 1'b1;
    tick();
    n_vec++; if (outs !== 33'h0) begin n_err++; $display("FAIL reset_release_outs: got %h expected 0", outs); end
    $display("test_reset: outputs=%h", outs);
  endtask

  task automatic test_single_write();
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    n_vec++; if ({bus.WrEn, bus.Address, bus.WrData} !== {1'b1, 4'h5, 8'h3C}) begin
      n_err++; $display("FAIL single_wr: got en=%b a=%h d=%h expected en=1 a=5 d=3c", bus.WrEn, bus.Address, bus.WrData); end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL single_wr_busy: got %b expected 0", bus.BUSY); end
    tick();
    n_vec++; if (bus.WrEn !== 1'b0) begin n_err++; $display("FAIL single_wr_pulse: got %b expected 0", bus.WrEn); end
    n_vec++; if (wr_q.size() != 1) begin n_err++; $display("FAIL single_wr_count: got %0d expected 1", wr_q.size()); end
    $display("test_single_write: writes=%0d", wr_q.size());
  endtask

  task automatic test_burst_write();
    logic [11:0] exp_w [3];
    exp_w = '{12'hE11, 12'hF22, 12'h033};
    clear_logs();
    send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tick();
    n_vec++; if (wr_q.size() != 3) begin n_err++; $display("FAIL burst_wr_count: got %0d expected 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (wr_q[i] !== exp_w[i]) begin n_err++; $display("FAIL burst_wr_%0d: got %h expected %h", i, wr_q[i], exp_w[i]); end
    end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL burst_wr_busy: got %b expected 0", bus.BUSY); end
    $display("test_burst_write: writes=%0d", wr_q.size());
  endtask

  task automatic test_burst_read();
    int n;
    int pushes;
    clear_logs();
    send_byte(8'hEF); send_byte(8'h03); send_byte(8'h01);
    n_vec++; if ({bus.RdEn, bus.Address} !== {1'b1, 4'h3}) begin
      n_err++; $display("FAIL rd_req0: got en=%b a=%h expected en=1 a=3", bus.RdEn, bus.Address); end
    tick(); tick();
    bus.RdData = 8'h7A; bus.RdData_Valid = 1'b1; tick(); bus.RdData_Valid = 1'b0;
    for (n = 0; n < 10 && bus.FIFO_W_INC !== 1'b1; n++) tick();
    n_vec++; if (n < 1 || n >= 10) begin n_err++; $display("FAIL rd_push0_latency: got %0d cycles expected 1..9", n); end
    n_vec++; if ({bus.RdEn, bus.Address} !== {1'b1, 4'h4}) begin
      n_err++; $display("FAIL rd_req1: got en=%b a=%h expected en=1 a=4", bus.RdEn, bus.Address); end
    bus.FIFO_FULL = 1'b1;
    tick();
    bus.RdData = 8'h7B; bus.RdData_Valid = 1'b1; tick(); bus.RdData_Valid = 1'b0;
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.FIFO_W_INC === 1'b1) pushes++;
    end
    n_vec++; if (pushes != 0) begin n_err++; $display("FAIL rd_full_stall: got %0d pushes expected 0", pushes); end
    bus.FIFO_FULL = 1'b0;
    for (n = 0; n < 10 && bus.FIFO_W_INC !== 1'b1; n++) tick();
    n_vec++; if (n >= 10) begin n_err++; $display("FAIL rd_push1_wait: got %0d cycles expected <10", n); end
    tick();
    n_vec++; if (push_q.size() != 2) begin n_err++; $display("FAIL rd_push_count: got %0d expected 2", push_q.size()); end
    n_vec++; if (push_q[0][7:0] !== 8'h7A) begin n_err++; $display("FAIL rd_push0: got %h expected 7a", push_q[0][7:0]); end
    n_vec++; if (push_q[1][7:0] !== 8'h7B) begin n_err++; $display("FAIL rd_push1: got %h expected 7b", push_q[1][7:0]); end
    n_vec++; if (err_q.size() != 0) begin n_err++; $display("FAIL rd_no_err: got %0d errors expected 0", err_q.size()); end
    n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b expected 0", bus.BUSY); end
    $display("test_burst_read: pushes=%0d", push_q.size());
  endtask

  task automatic test_alu();
    int n;
    clear_logs();
    send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    n_vec++; if ({bus.ALU_EN, bus.ALU_FUN, bus.GATE_EN} !== {1'b1, 4'h0, 1'b1}) begin
      n_err++; $display("FAIL alu_cc_start: got en=%b fun=%h gate=%b expected en=1 fun=0 gate=1", bus.ALU_EN, bus.ALU_FUN, bus.GATE_EN); end
    tick();
    bus.ALU_OUT = 16'h0030; bus.OUT_VALID = 1'b1; tick(); bus.OUT_VALID = 1'b0;
    for (n = 0; n < 20 && bus.BUSY !== 1'b0; n++) tick();
    tick();
    n_vec++; if (wr_q.size() != 2 || wr_q[0] !== 12'h010 || wr_q[1] !== 12'h120) begin
      n_err++; $display("FAIL alu_cc_opwr: got n=%0d %h %h expected 010 120", wr_q.size(), wr_q[0], wr_q[1]); end
    n_vec++; if (push_q.size() != 1 || push_q[0] !== 9'h130) begin
      n_err++; $display("FAIL alu_cc_push: got n=%0d %h expected 1 push of gate+30", push_q.size(), push_q[0]); end
    n_vec++; if (bus.GATE_EN !== 1'b0) begin n_err++; $display("FAIL alu_cc_gate_off: got %b expected 0", bus.GATE_EN); end
    $display("test_alu CC: pushes=%0d", push_q.size());

    clear_logs();
    send_byte(8'hDD); send_byte(8'h02);
    n_vec++; if ({bus.ALU_EN, bus.ALU_FUN} !== {1'b1, 4'h2}) begin
      n_err++; $display("FAIL alu_dd_start: got en=%b fun=%h expected en=1 fun=2", bus.ALU_EN, bus.ALU_FUN); end
    tick();
    bus.ALU_OUT = 16'h0200; bus.OUT_VALID = 1'b1; tick(); bus.OUT_VALID = 1'b0;
    for (n = 0; n < 20 && bus.BUSY !== 1'b0; n++) tick();
    tick();
    n_vec++; if (push_q.size() != 2 || push_q[0] !== 9'h100 || push_q[1] !== 9'h102) begin
      n_err++; $display("FAIL alu_dd_push: got n=%0d %h %h expected 100 102", push_q.size(), push_q[0], push_q[1]); end
    $display("test_alu DD: pushes=%0d", push_q.size());
  endtask

  task automatic test_timeout();
    int n;
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05);
    for (n = 0; n < TIMEOUT + 20 && bus.FRAME_ERR !== 1'b1; n++) tick();
    n_vec++; if (n != TIMEOUT + 1) begin n_err++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TIMEOUT + 1); end
    n_vec++; if ({bus.ERR_CODE, bus.BUSY, bus.WrEn} !== {2'b01, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL tmo_state: got code=%b busy=%b wren=%b expected 01 0 0", bus.ERR_CODE, bus.BUSY, bus.WrEn); end
    tick();
    n_vec++; if ({bus.FRAME_ERR, bus.ERR_CODE} !== {1'b0, 2'b01}) begin
      n_err++; $display("FAIL tmo_pulse_hold: got err=%b code=%b expected 0 01", bus.FRAME_ERR, bus.ERR_CODE); end
    n_vec++; if (wr_q.size() != 0) begin n_err++; $display("FAIL tmo_no_wr: got %0d writes expected 0", wr_q.size()); end
    $display("test_timeout: abort after %0d idle cycles", n);
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h99);
    n_vec++; if ({bus.FRAME_ERR, bus.ERR_CODE, bus.BUSY} !== {1'b1, 2'b10, 1'b0}) begin
      n_err++; $display("FAIL bad_op: got err=%b code=%b busy=%b expected 1 10 0", bus.FRAME_ERR, bus.ERR_CODE, bus.BUSY); end
    $display("test_bad_opcode: code=%b", bus.ERR_CODE);
  endtask

  task automatic test_drop_in_alu_wait();
    int n;
    clear_logs();
    send_byte(8'hDD); send_byte(8'h05);
    tick();
    send_byte(8'hAB);
    n_vec++; if ({bus.FRAME_ERR, bus.ERR_CODE, bus.BUSY} !== {1'b1, 2'b11, 1'b1}) begin
      n_err++; $display("FAIL drop_err: got err=%b code=%b busy=%b expected 1 11 1", bus.FRAME_ERR, bus.ERR_CODE, bus.BUSY); end
    bus.ALU_OUT = 16'h1234; bus.OUT_VALID = 1'b1; tick(); bus.OUT_VALID = 1'b0;
    for (n = 0; n < 20 && bus.BUSY !== 1'b0; n++) tick();
    tick();
    n_vec++; if (push_q.size() != 2 || push_q[0] !== 9'h134 || push_q[1] !== 9'h112) begin
      n_err++; $display("FAIL drop_push: got n=%0d %h %h expected 134 112", push_q.size(), push_q[0], push_q[1]); end
    $display("test_drop_in_alu_wait: pushes=%0d", push_q.size());
  endtask

  task automatic test_reset_mid_burst();
    send_byte(8'hEE); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22);
    n_vec++; if ({bus.WrEn, bus.BUSY} !== 2'b11) begin
      n_err++; $display("FAIL rst_pre: got wren=%b busy=%b expected 1 1", bus.WrEn, bus.BUSY); end
    RST = 1'b0;
    #1;
    n_vec++; if (outs !== 33'h0) begin n_err++; $display("FAIL rst_mid_outs: got %h expected 0", outs); end
    tick(); tick();
    RST = 1'b1;
    tick();
    send_byte(8'h44);
    n_vec++; if ({bus.FRAME_ERR, bus.ERR_CODE} !== {1'b1, 2'b10}) begin
      n_err++; $display("FAIL rst_idle_after: got err=%b code=%b expected 1 10", bus.FRAME_ERR, bus.ERR_CODE); end
    $display("test_reset_mid_burst: outputs after reset=%h", outs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0;
    bus.RdData = '0; bus.RdData_Valid = 1'b0;
    bus.ALU_OUT = '0; bus.OUT_VALID = 1'b0;
    bus.FIFO_FULL = 1'b0;
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_alu();
    test_timeout();
    test_bad_opcode();
    test_drop_in_alu_wait();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_frame_ctrl.md
# cmd_frame_ctrl

Command-frame controller between the UART receiver, register file, ALU and TX FIFO of the multi-clock system, in the REF_CLK domain. It decodes byte frames from RX, performs single or burst register writes and reads, and runs ALU operations with in-frame or stored operands. It returns results through the TX FIFO as a variable number of bytes. It adds configurable widths and operand addresses, burst transfers, an inter-byte timeout and error reporting.

## Interface
- DSIZE, 8, data byte width; RX_P_DATA, WrData, RdData and FIFO_WR_DATA width
- ASIZE, 4, register-file address width
- OUT_SIZE, 16, ALU result width; must be a multiple of DSIZE; NB = OUT_SIZE/DSIZE
- FUN_W, 4, ALU function width
- OPA_ADDR, 0, register address of operand A
- OPB_ADDR, 1, register address of operand B
- TIMEOUT, 1023, idle cycles allowed mid-frame before the frame aborts; must be ≥1

Ports:
- CLK  in  1  clock. One clock; all logic is on its rising edge.
- RST  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  DSIZE  received byte
- RX_D_VLD  in  1  one-cycle strobe qualifying RX_P_DATA
- RdData  in  DSIZE  register-file read data
- RdData_Valid  in  1  read data valid
- ALU_OUT  in  OUT_SIZE  ALU result
- OUT_VALID  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full
- WrEn, RdEn  out  1  register-file write and read strobes
- Address  out  ASIZE  register-file address
- WrData  out  DSIZE  register-file write data
- ALU_EN  out  1  one-cycle ALU start
- ALU_FUN  out  FUN_W  ALU function code
- GATE_EN  out  1  ALU clock-gate enable
- FIFO_WR_DATA  out  DSIZE  TX FIFO write data
- FIFO_W_INC  out  1  TX FIFO push
- BUSY  out  1  high whenever state ≠ IDLE
- FRAME_ERR  out  1  one-cycle error pulse
- ERR_CODE  out  2  error cause: 01 timeout, 10 bad opcode, 11 byte dropped; holds until the next error

## Operation
- Frames, with each byte qualified by RX_D_VLD:
  - AA: addr, data
  - BB: addr
  - CC: opA, opB, fun
  - DD: fun
  - EE: addr, len, then len+1 data bytes
  - EF: addr, len
- Burst length is len+1, range 1..256. Address increments after each access and wraps modulo 2^ASIZE.
- States and transitions:
  - IDLE → GET_ADDR on AA, BB, EE or EF; → GET_OPA on CC; → GET_FUN on DD.
  - Any other byte keeps IDLE and raises FRAME_ERR with code 10.
  - GET_ADDR → GET_DATA on AA or EE (EE passes through GET_LEN first); → RD_REQ on BB or EF (EF passes through GET_LEN first).
  - GET_DATA: each byte drives WrEn=1 with WrData=byte for one cycle, registered. The state exits to IDLE after the last byte.
  - RD_REQ drives a one-cycle RdEn, then → RD_WAIT.
  - RD_WAIT captures RdData when RdData_Valid=1, then → RD_PUSH.
  - RD_PUSH: FIFO_W_INC=1 in the first cycle with FIFO_FULL=0. Then → RD_REQ if burst bytes remain, else → IDLE.
  - GET_OPA and GET_OPB each write their byte to OPA_ADDR and OPB_ADDR respectively.
  - GET_FUN: ALU_FUN=byte[FUN_W-1:0] and ALU_EN pulses for one cycle; → ALU_WAIT.
  - ALU_WAIT latches ALU_OUT on OUT_VALID, then → ALU_PUSH.
  - ALU_PUSH pushes result bytes LSB first, one per non-full cycle. It stops after byte k, where k is the index of the highest non-zero byte (minimum 1 byte).
- GATE_EN is high from the fun byte until the final ALU byte is pushed.
- A byte arriving in RD_*, ALU_WAIT or ALU_PUSH is dropped and raises FRAME_ERR with code 11. The current operation continues.

## Timing
- Reset values: every output is 0 and Address=0. State is IDLE.
- All outputs are registered. Each action appears one cycle after its enabling RX_D_VLD, RdData_Valid or OUT_VALID.
- A single write completes 1 cycle after the data byte.
- A read pushes no earlier than 2 cycles after RdData_Valid.
- The timeout counter clears on every accepted byte or valid.
- Timeout applies in every non-IDLE state except RD_PUSH and ALU_PUSH, where FIFO_FULL stalls indefinitely without error.
- When the counter reaches TIMEOUT, the next state is IDLE, FRAME_ERR pulses with code 01 and all strobes drop.
- RST asserted mid-operation returns everything to reset values immediately.
- Address auto-increment: 2^ASIZE−1 followed by 0.

## Structure
- Package cmd_frame_pkg holds:
  - opcode constants AA, BB, CC, DD, EE and EF
  - the state enum
  - the ERR_CODE constants
- One sub-module, frame_timeout_cnt: a loadable down-counter of width $clog2(TIMEOUT+1) with inputs clr and en and output expire.

## Test plan
- AA,05,3C → WrEn for 1 cycle with Address=5 and WrData=3C, then BUSY=0.
- EE,0E,02,11,22,33 → writes 11@E, 22@F and 33@0 (wrap check).
- EF,03,01 with RdData 7A then 7B → FIFO receives 7A,7B. FIFO_FULL held for 5 cycles before the second push → push is delayed and no error is raised.
- CC,10,20,00 with ALU_OUT=0030 → writes to addr 0 and 1, ALU_FUN=0, exactly 1 push of 30. DD,02 with ALU_OUT=0200 → pushes 00 then 02.
- AA,05 then silence for TIMEOUT cycles → FRAME_ERR, ERR_CODE=01, IDLE, no WrEn. Byte 99 in IDLE → FRAME_ERR, ERR_CODE=10.
- Byte received during ALU_WAIT → FRAME_ERR, ERR_CODE=11, and the ALU result is still pushed. RST pulse mid-burst → all outputs return to 0.
